// File: rtl/dot_product_accumulator_pkg.sv
// Shared types and constants for the dot-product accumulator and its output stages.
package mac_pkg;

    localparam int PROD_W_DEF = 64;
    localparam int ACC_W_DEF  = 72;
    localparam int LEN_W_DEF  = 8;

    localparam logic [PROD_W_DEF-1:0] SAT_POS = {1'b0, {(PROD_W_DEF-1){1'b1}}};
    localparam logic [PROD_W_DEF-1:0] SAT_NEG = {1'b1, {(PROD_W_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

endpackage

// File: rtl/dot_product_accumulator_sat_clamp.sv
// Combinational clamp of a wide signed accumulator into the signed product range.
module sat_clamp
    import mac_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int PROD_W = PROD_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    output logic [PROD_W-1:0] sat,
    output logic              ovf
);

    // In range exactly when every bit from the PROD_W sign bit upward agrees.
    logic [ACC_W-PROD_W:0] upper;

    assign upper = acc[ACC_W-1:PROD_W-1];

    always_comb begin
        sat = acc[PROD_W-1:0];
        ovf = 1'b0;
        if (!(&upper) && (|upper)) begin
            ovf = 1'b1;
            sat = acc[ACC_W-1] ? SAT_NEG : SAT_POS;
        end
    end

endmodule

// File: rtl/dot_product_accumulator.sv
// Accumulates programmable-length runs of signed products and hands the sum,
// plus a saturated copy, downstream over valid/ready.
module dot_product_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] in_prod,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_acc,
    output logic [PROD_W-1:0] out_sat,
    output logic              out_ovf,
    input  logic              out_ready
);

    localparam int CNT_W = LEN_W + 1;

    state_t             state, state_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   len_q, len_n;
    logic [CNT_W-1:0]   cfg_len_eff;
    logic [ACC_W-1:0]   prod_ext;
    logic               accept;
    logic               finish;
    logic               out_valid_n;
    logic [PROD_W-1:0]  sat_n;
    logic               ovf_n;

    assign prod_ext    = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
    assign cfg_len_eff = (cfg_len == '0) ? CNT_W'(1 << LEN_W) : {1'b0, cfg_len};

    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE, ACCUM: in_ready = 1'b1;
            DONE:        in_ready = out_ready;
            default:     in_ready = 1'b0;
        endcase
        in_ready = in_ready & rst;
    end

    assign accept = in_valid && in_ready && !flush;

    // A new run starts from IDLE or from DONE while the old result is taken,
    // which is what lets back-to-back runs proceed without a bubble.
    always_comb begin
        state_n     = state;
        acc_n       = acc;
        cnt_n       = cnt;
        len_n       = len_q;
        finish      = 1'b0;
        out_valid_n = out_valid;
        if (flush) begin
            state_n     = IDLE;
            cnt_n       = '0;
            out_valid_n = 1'b0;
        end else begin
            if (state == DONE && out_ready) begin
                state_n     = IDLE;
                out_valid_n = 1'b0;
            end
            if (accept) begin
                if (state == ACCUM) begin
                    acc_n = acc + prod_ext;
                    cnt_n = cnt + 1'b1;
                end else begin
                    len_n = cfg_len_eff;
                    acc_n = prod_ext;
                    cnt_n = CNT_W'(1);
                end
                if (cnt_n == len_n) begin
                    state_n     = DONE;
                    out_valid_n = 1'b1;
                    finish      = 1'b1;
                end else begin
                    state_n = ACCUM;
                end
            end
        end
    end

    sat_clamp #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_sat_clamp (
        .acc (acc_n),
        .sat (sat_n),
        .ovf (ovf_n)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len_q     <= '0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_sat   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            len_q     <= len_n;
            out_valid <= out_valid_n;
            if (finish) begin
                out_acc <= acc_n;
                out_sat <= sat_n;
                out_ovf <= ovf_n;
            end
        end
    end

endmodule

// File: doc/dot_product_accumulator.md
Name: dot_product_accumulator

Overview:
- Downstream consumer of the pipelined 32x32 signed tree multiplier.
- Accumulates a programmable-length run of signed 64-bit products into a 72-bit accumulator.
- Presents the accumulator result, plus a 64-bit saturated copy, over a valid/ready handshake.
- Turns the multiplier into a dot-product / MAC engine for the downstream filter datapath.

Parameters:
- PROD_W, 64, width of the signed product from the multiplier.
- ACC_W, 72, accumulator width; PROD_W+LEN_W guarantees no internal overflow.
- LEN_W, 8, width of the run-length configuration field.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low; asserts without a clock edge, deasserts synchronously to clk.
- flush  input  1  synchronous abort; drops any partial or held result.
- cfg_len  input  LEN_W  number of terms per run; sampled only on the first term of a run; 0 means 256 terms.
- in_valid  input  1  the product on in_prod is valid.
- in_prod  input  PROD_W  signed product from the multiplier output register.
- in_ready  output  1  the block accepts in_prod this cycle.
- out_valid  output  1  a completed run is held on the outputs.
- out_acc  output  ACC_W  signed full-precision sum.
- out_sat  output  PROD_W  out_acc clamped to the signed PROD_W range.
- out_ovf  output  1  set when out_acc lies outside the signed PROD_W range.
- out_ready  input  1  the consumer takes the result.

Behaviour:
- Reset (rst low): state IDLE; acc=0; cnt=0; len_q=0.
- Reset output values: in_ready=0 while rst is low; out_valid=0; out_acc=0; out_sat=0; out_ovf=0.
- A reset in the middle of a run discards the run, and no output is produced.
- Accept event: in_valid && in_ready. Output event: out_valid && out_ready.
- Input products are sign-extended to ACC_W before accumulation. Addition is two's complement and cannot wrap for runs of up to 256 terms.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On accept: len_q = (cfg_len==0) ? 256 : cfg_len; acc = sext(in_prod); cnt = 1.
  - Next state is DONE if len_q==1, otherwise ACCUM.
- ACCUM:
  - in_ready=1.
  - On accept: acc += sext(in_prod); cnt += 1.
  - If the new cnt == len_q, go to DONE.
  - Cycles without in_valid hold all state; there is no timeout.
- DONE:
  - out_valid=1. out_acc, out_sat and out_ovf are registered from acc.
  - in_ready = out_ready.
  - Output event without an accept: go to IDLE.
  - Output event with an accept in the same cycle: the new run starts exactly as in IDLE, and cfg_len is sampled then. This gives back-to-back runs with no bubble.
  - out_ready low: hold all outputs stable, and keep in_ready=0.
- Latency: out_valid rises on the clock edge that accepts the last term, so it is visible in the following cycle.
- Saturation:
  - out_sat = 0x7FFF_FFFF_FFFF_FFFF when acc > 2^63-1.
  - out_sat = 0x8000_0000_0000_0000 when acc < -2^63.
  - Otherwise out_sat = acc[63:0].
  - out_ovf is high exactly in the two clamped cases.
- flush:
  - Highest priority after reset.
  - Next state is IDLE; cnt=0; out_valid=0.
  - Any in_prod presented in the same cycle is dropped, even if in_ready is high.
- cfg_len changes in the middle of a run are ignored.
- All outputs are driven from registers; there is no combinational path from in_prod to out_*.

Decomposition:
- Shared package (mac_pkg) holds:
  - state enum {IDLE, ACCUM, DONE};
  - PROD_W, ACC_W, LEN_W defaults;
  - the constants SAT_POS and SAT_NEG.
- Sub-module sat_clamp: purely combinational, ACC_W to PROD_W, outputs the clamped value and the ovf flag. It is reused by later output stages.
- The FSM, counter and accumulator stay in the top module.

Test Plan:
- Single run: cfg_len=3, products 5, -2, 10, out_ready=1 → one out_valid pulse with out_acc=13, out_sat=13, out_ovf=0. out_valid is visible the cycle after the 3rd accept.
- Backpressure and back-to-back:
  - cfg_len=2 with products 1, 1; hold out_ready=0 for 4 cycles → in_ready=0 and outputs stable at 2.
  - Raise out_ready while presenting product 7 with cfg_len=1 → the next result is 7, with no idle cycle in between.
- Saturation: cfg_len=2 with products 0x7FFF_FFFF_FFFF_FFFF twice → out_acc=0x0_FFFF_FFFF_FFFF_FFFE (72-bit), out_sat=0x7FFF_FFFF_FFFF_FFFF, out_ovf=1.
- Negative clamp and length 0:
  - cfg_len=0 with 256 products of -2^63 → out_acc=-2^71, out_sat=0x8000_0000_0000_0000, out_ovf=1.
  - out_valid must appear only after the 256th accept.
- Flush and reset mid-run:
  - cfg_len=4; after 2 terms assert flush with in_valid=1 → no output; a following 4-term run of 1s yields 4.
  - Repeat with rst pulsed low between clock edges → outputs go to 0 immediately, with no result.
- Idle gaps: cfg_len=3; products 100, 200, 300 separated by 5-cycle in_valid=0 gaps → out_acc=600.
